// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: widths, expunit status bits,
// the exp sequencer state encoding and the exp lookup tables.
package softmax_pkg;

  localparam int unsigned FP16_W       = 16;
  localparam int unsigned EXP_STATUS_W = 8;

  // expunit status bit positions
  localparam int unsigned STAT_INVALID  = 0; // NaN input, result is qNaN
  localparam int unsigned STAT_POSITIVE = 1; // positive input clamped to 0
  localparam int unsigned STAT_SAT      = 2; // |x| beyond table range, clamped
  localparam int unsigned STAT_INEXACT  = 3; // input not on the table grid
  localparam int unsigned STAT_NEG_INF  = 4; // -inf input, result exactly 0

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } exp_seq_state_t;

  // exp(-n) for n = 0..7, fp16 without sign bit
  function automatic logic [14:0] exp_int_lut(input logic [2:0] n);
    logic [14:0] r;
    case (n)
      3'd0:    r = 15'h3C00;
      3'd1:    r = 15'h35E3;
      3'd2:    r = 15'h3055;
      3'd3:    r = 15'h2A5F;
      3'd4:    r = 15'h24B0;
      3'd5:    r = 15'h1EE6;
      3'd6:    r = 15'h1914;
      default: r = 15'h1378;
    endcase
    return r;
  endfunction

  // exp(-f/8) for f = 0..7, fp16 without sign bit
  function automatic logic [14:0] exp_frac_lut(input logic [2:0] f);
    logic [14:0] r;
    case (f)
      3'd0:    r = 15'h3C00;
      3'd1:    r = 15'h3B0F;
      3'd2:    r = 15'h3A3B;
      3'd3:    r = 15'h3980;
      3'd4:    r = 15'h38DA;
      3'd5:    r = 15'h3848;
      3'd6:    r = 15'h378F;
      default: r = 15'h36AB;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exp_seq_ctrl_expunit.sv
// expunit: fp16 exp(x) for x <= 0. The input is quantised to a fixed-point
// table index and registered (one stage, enabled by stage_run); the output
// is exp(-int) * exp(-frac/8) from two small tables, rounded to fp16.
module expunit
  import softmax_pkg::*;
#(
  parameter int unsigned INT_WIDTH  = 3,
  parameter int unsigned FRAC_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stage_run,
  input  logic [FP16_W-1:0]       a,
  output logic [FP16_W-1:0]       z,
  output logic [EXP_STATUS_W-1:0] status
);

  localparam int unsigned IDX_W   = INT_WIDTH + FRAC_WIDTH;
  localparam int unsigned IDX_MAX = (1 << IDX_W) - 1;
  // |x| * 2^FRAC = sig * 2^(exp - 25 + FRAC); exponents at or above this
  // value always exceed the table range
  localparam int unsigned SH_BASE = 25 - FRAC_WIDTH;

  logic [4:0]              a_exp;
  logic [31:0]             a_sig;
  logic [IDX_W-1:0]        idx_d, idx_q;
  logic                    nan_d, nan_q, ninf_d, ninf_q;
  logic [EXP_STATUS_W-1:0] st_d, st_q;
  int unsigned             sh;
  logic [31:0]             scaled, lost_mask;

  assign a_exp = a[14:10];
  assign a_sig = {21'b0, 1'b1, a[9:0]};

  // Quantise the input to a round-to-nearest table index and classify it
  always_comb begin
    idx_d     = '0;
    nan_d     = 1'b0;
    ninf_d    = 1'b0;
    st_d      = '0;
    sh        = 0;
    scaled    = '0;
    lost_mask = '0;
    if (a_exp == 5'h1F) begin
      if (a[9:0] != '0) begin
        nan_d              = 1'b1;
        st_d[STAT_INVALID] = 1'b1;
      end else if (a[15]) begin
        ninf_d             = 1'b1;
        st_d[STAT_NEG_INF] = 1'b1;
      end else begin
        st_d[STAT_POSITIVE] = 1'b1;
      end
    end else if (!a[15] && a[14:0] != '0) begin
      st_d[STAT_POSITIVE] = 1'b1;
    end else if (a_exp == 5'h00) begin
      st_d[STAT_INEXACT] = (a[9:0] != '0);
    end else if (a_exp >= SH_BASE) begin
      idx_d          = IDX_W'(IDX_MAX);
      st_d[STAT_SAT] = 1'b1;
    end else begin
      sh        = SH_BASE - {27'b0, a_exp};
      scaled    = (a_sig >> sh) + ((a_sig >> (sh - 1)) & 32'd1);
      lost_mask = (32'd1 << sh) - 32'd1;
      st_d[STAT_INEXACT] = ((a_sig & lost_mask) != '0);
      if (scaled > IDX_MAX) begin
        idx_d          = IDX_W'(IDX_MAX);
        st_d[STAT_SAT] = 1'b1;
      end else begin
        idx_d = scaled[IDX_W-1:0];
      end
    end
  end

  // Single pipeline register, loaded whenever the stage runs
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      nan_q  <= 1'b0;
      ninf_q <= 1'b0;
      st_q   <= '0;
    end else if (stage_run) begin
      idx_q  <= idx_d;
      nan_q  <= nan_d;
      ninf_q <= ninf_d;
      st_q   <= st_d;
    end
  end

  assign status = st_q;

  logic [14:0] ha, hb;
  logic [21:0] prod;
  logic        p_lsb, p_guard, p_sticky;
  logic [11:0] mant_ext;
  logic [1:0]  e_adj;
  logic [4:0]  exp_sum;
  logic [9:0]  mant_out;

  // Multiply the two table factors; round to nearest even (results stay normal)
  always_comb begin
    ha   = exp_int_lut(3'(idx_q[IDX_W-1:FRAC_WIDTH]));
    hb   = exp_frac_lut(3'(idx_q[FRAC_WIDTH-1:0]));
    prod = {11'b0, 1'b1, ha[9:0]} * {11'b0, 1'b1, hb[9:0]};
    if (prod[21]) begin
      p_lsb    = prod[11];
      p_guard  = prod[10];
      p_sticky = |prod[9:0];
      mant_ext = {1'b0, prod[21:11]};
      e_adj    = 2'd1;
    end else begin
      p_lsb    = prod[10];
      p_guard  = prod[9];
      p_sticky = |prod[8:0];
      mant_ext = {1'b0, prod[20:10]};
      e_adj    = 2'd0;
    end
    mant_ext = mant_ext + {11'b0, p_guard & (p_sticky | p_lsb)};
    if (mant_ext[11]) begin
      e_adj    = e_adj + 2'd1;
      mant_out = mant_ext[10:1];
    end else begin
      mant_out = mant_ext[9:0];
    end
    exp_sum = ha[14:10] + hb[14:10] + {3'b0, e_adj} - 5'd15;
    if (nan_q)       z = 16'h7E00;
    else if (ninf_q) z = '0;
    else             z = {1'b0, exp_sum, mant_out};
  end

endmodule

// File: rtl/exp_seq_ctrl.sv
// exp_seq_ctrl: streams a vector of fp16 elements through one expunit with
// full-rate handshaking, element counting, last marking and status collection.
module exp_seq_ctrl
  import softmax_pkg::*;
#(
  parameter int unsigned LEN_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FP16_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP16_W-1:0]       out_data,
  output logic                    out_last,
  output logic [EXP_STATUS_W-1:0] status_acc
);

  exp_seq_state_t          state, state_next;
  logic [LEN_W-1:0]        len_q, in_cnt, out_cnt;
  logic                    stg_v;
  logic                    advance, accept, deliver, exp_stage_run;
  logic [EXP_STATUS_W-1:0] exp_status;

  // The stage moves when it is empty or its content is being taken
  always_comb begin
    advance       = (state == RUN) && (!stg_v || out_ready);
    in_ready      = advance && (in_cnt < len_q);
    accept        = in_valid && in_ready;
    exp_stage_run = advance;
    out_valid     = stg_v;
    out_last      = stg_v && (out_cnt == len_q - LEN_W'(1));
    deliver       = out_valid && out_ready;
    busy          = (state != IDLE);
  end

  expunit #(
    .INT_WIDTH  (3),
    .FRAC_WIDTH (3)
  ) u_exp (
    .clk       (clk),
    .reset     (reset),
    .stage_run (exp_stage_run),
    .a         (in_data),
    .z         (out_data),
    .status    (exp_status)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: leave IDLE on a non-empty start, return after the last deliver
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && len != '0) state_next = RUN;
      RUN:     if (deliver && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Length latch, counters, stage valid, status accumulation and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      stg_v      <= 1'b0;
      status_acc <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          status_acc <= '0;
          if (len != '0) begin
            len_q   <= len;
            in_cnt  <= '0;
            out_cnt <= '0;
          end else begin
            done <= 1'b1;
          end
        end
      end else begin
        if (advance) stg_v <= accept;
        if (accept) in_cnt <= in_cnt + LEN_W'(1);
        if (deliver) begin
          out_cnt    <= out_cnt + LEN_W'(1);
          status_acc <= status_acc | exp_status;
          if (out_last) done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_seq_ctrl.sv
// Directed self-checking bench for exp_seq_ctrl.
module tb_exp_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [9:0]  len;
  logic [15:0] in_data;
  logic        busy, done, in_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic [7:0]  status_acc;

  int n_cmp = 0;
  int n_bad = 0;

  exp_seq_ctrl #(.LEN_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .status_acc (status_acc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (status_acc !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h want 00", status_acc); end
    n_cmp++; if (out_data !== 16'h3C00) begin n_bad++; $display("FAIL reset_out_data: got %h want 3c00", out_data); end
  endtask

  task automatic test_single();
    start = 1'b1; len = 10'd1; step(); start = 1'b0; len = '0;
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1; #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_out_valid_early: got %b want 0", out_valid); end
    step(); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL single_out_last: got %b want 1", out_last); end
    n_cmp++; if (out_data !== 16'h3C00) begin n_bad++; $display("FAIL single_out_data: got %h want 3c00", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL single_in_ready_after: got %b want 0", in_ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_early: got %b want 0", done); end
    step(); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_out_valid_end: got %b want 0", out_valid); end
    step(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_lut_point();
    start = 1'b1; len = 10'd1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'hBC00; out_ready = 1'b1; #1;
    step(); in_valid = 1'b0; #1;
    n_cmp++; if (out_data !== 16'h35E3) begin n_bad++; $display("FAIL lut_out_data: got %h want 35e3", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL lut_out_last: got %b want 1", out_last); end
    step(); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL lut_done: got %b want 1", done); end
    n_cmp++; if (status_acc !== 8'h00) begin n_bad++; $display("FAIL lut_status: got %h want 00", status_acc); end
  endtask

  task automatic test_streaming();
    logic [15:0] din  [8] = '{16'h0000, 16'hBC00, 16'hC000, 16'hC200,
                              16'hB800, 16'hB400, 16'hC400, 16'hB000};
    logic [15:0] dexp [8] = '{16'h3C00, 16'h35E3, 16'h3055, 16'h2A5F,
                              16'h38DA, 16'h3A3B, 16'h24B0, 16'h3B0F};
    start = 1'b1; len = 10'd8; step(); start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8);
      in_data  = (i < 8) ? din[i] : 16'h0000;
      #1;
      n_cmp++; if (in_ready !== (i < 8)) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b want %b", i, in_ready, (i < 8)); end
      if (i > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
        n_cmp++; if (out_data !== dexp[i-1]) begin n_bad++; $display("FAIL stream_out_data[%0d]: got %h want %h", i, out_data, dexp[i-1]); end
        n_cmp++; if (out_last !== (i == 8)) begin n_bad++; $display("FAIL stream_out_last[%0d]: got %b want %b", i, out_last, (i == 8)); end
      end
      step();
    end
    #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stream_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_busy: got %b want 0", busy); end
    n_cmp++; if (status_acc !== 8'h00) begin n_bad++; $display("FAIL stream_status: got %h want 00", status_acc); end
  endtask

  task automatic test_backpressure();
    logic        ordy [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
    logic        ival [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [15:0] din  [8] = '{16'hBE00, 16'hC000, 16'hC000, 16'hC000,
                              16'hC000, 16'hB800, 16'hBC00, 16'h0000};
    logic        e_ir [8] = '{1, 0, 0, 0, 1, 1, 1, 0};
    logic        e_ov [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    logic [15:0] e_od [8] = '{16'h0000, 16'h3324, 16'h3324, 16'h3324,
                              16'h3324, 16'h3055, 16'h38DA, 16'h35E3};
    logic        e_ol [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    start = 1'b1; len = 10'd4; step(); start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      out_ready = ordy[c]; in_valid = ival[c]; in_data = din[c];
      #1;
      n_cmp++; if (in_ready !== e_ir[c]) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, e_ir[c]); end
      n_cmp++; if (out_valid !== e_ov[c]) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want %b", c, out_valid, e_ov[c]); end
      if (e_ov[c]) begin
        n_cmp++; if (out_data !== e_od[c]) begin n_bad++; $display("FAIL bp_out_data[%0d]: got %h want %h", c, out_data, e_od[c]); end
      end
      n_cmp++; if (out_last !== e_ol[c]) begin n_bad++; $display("FAIL bp_out_last[%0d]: got %b want %b", c, out_last, e_ol[c]); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL bp_done_early[%0d]: got %b want 0", c, done); end
      step();
    end
    in_valid = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_len();
    in_valid = 1'b0; out_ready = 1'b1;
    start = 1'b1; len = 10'd0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_pre: got %b want 0", busy); end
    step(); start = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    step(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_busy_start();
    start = 1'b1; len = 10'd2; step();
    start = 1'b1; len = 10'd5;
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1; #1;
    step(); start = 1'b0; len = '0; in_data = 16'hC000; #1;
    n_cmp++; if (out_data !== 16'h3C00) begin n_bad++; $display("FAIL busy_out0: got %h want 3c00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL busy_last0: got %b want 0", out_last); end
    step(); in_valid = 1'b0; #1;
    n_cmp++; if (out_data !== 16'h3055) begin n_bad++; $display("FAIL busy_out1: got %h want 3055", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL busy_last1: got %b want 1", out_last); end
    step(); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL busy_done: got %b want 1", done); end
    step(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_restart: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 10'd5; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b1; #1;
    step(); in_data = 16'h7E00; #1;
    n_cmp++; if (out_data !== 16'h3C00) begin n_bad++; $display("FAIL rmid_out0: got %h want 3c00", out_data); end
    step(); in_data = 16'h0000; #1;
    n_cmp++; if (out_data !== 16'h7E00) begin n_bad++; $display("FAIL rmid_out1: got %h want 7e00", out_data); end
    step(); #1;
    n_cmp++; if (status_acc !== 8'h03) begin n_bad++; $display("FAIL rmid_status_acc: got %h want 03", status_acc); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
    reset = 1'b1; step(); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_done: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rmid_rst_out_last: got %b want 0", out_last); end
    n_cmp++; if (status_acc !== 8'h00) begin n_bad++; $display("FAIL rmid_rst_status: got %h want 00", status_acc); end
    n_cmp++; if (out_data !== 16'h3C00) begin n_bad++; $display("FAIL rmid_rst_out_data: got %h want 3c00", out_data); end
    reset = 1'b0; in_valid = 1'b0;
    start = 1'b1; len = 10'd1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'hBC00; #1;
    step(); in_valid = 1'b0; #1;
    n_cmp++; if (out_data !== 16'h35E3) begin n_bad++; $display("FAIL rmid_new_out: got %h want 35e3", out_data); end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL rmid_new_last: got %b want 1", out_last); end
    step(); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rmid_new_done: got %b want 1", done); end
    n_cmp++; if (status_acc !== 8'h00) begin n_bad++; $display("FAIL rmid_new_status: got %h want 00", status_acc); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    test_reset();
    reset = 1'b0;
    test_single();
    test_lut_point();
    test_streaming();
    test_backpressure();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
